// File: rtl/cache_line_transfer_ctrl_pkg.sv
// Shared types and constants for the cache line writeback/refill controller.
package cache_line_transfer_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WB_REQ,
      ST_FILL_REQ,
      ST_FILL_WAIT,
      ST_DONE
   } state_t;

   // Ceiling log2 with a floor of one bit, for counter and index widths.
   function automatic int unsigned log(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   localparam int unsigned DEF_CACHE_BLOCK   = 512;
   localparam int unsigned DEF_MEM_BUS_WIDTH = 64;
   localparam int unsigned BEATS             = DEF_CACHE_BLOCK / DEF_MEM_BUS_WIDTH;
   localparam int unsigned BEAT_CNT_W        = log(BEATS);

endpackage

// File: rtl/cache_line_transfer_ctrl_if.sv
// Cache-side and memory-side signals of the line transfer controller.
interface cache_line_transfer_ctrl_if #(
   parameter int unsigned CACHE_BLOCK   = 512,
   parameter int unsigned MEM_BUS_WIDTH = 64,
   parameter int unsigned ADDRESS_WIDTH = 32
);
   logic                     replace_req_in;
   logic                     dirty_bit_in;
   logic [ADDRESS_WIDTH-1:0] victim_addr_in;
   logic [ADDRESS_WIDTH-1:0] fill_addr_in;
   logic [CACHE_BLOCK-1:0]   block_data_in;
   logic [CACHE_BLOCK-1:0]   block_data_out;
   logic                     replace_ack_out;
   logic                     busy_out;
   logic                     mem_req_out;
   logic                     mem_we_out;
   logic [ADDRESS_WIDTH-1:0] mem_addr_out;
   logic [MEM_BUS_WIDTH-1:0] mem_wdata_out;
   logic                     mem_ready_in;
   logic                     mem_rvalid_in;
   logic [MEM_BUS_WIDTH-1:0] mem_rdata_in;

   modport master (
      input  replace_req_in, dirty_bit_in, victim_addr_in, fill_addr_in, block_data_in,
      input  mem_ready_in, mem_rvalid_in, mem_rdata_in,
      output block_data_out, replace_ack_out, busy_out,
      output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out
   );

   modport slave (
      output replace_req_in, dirty_bit_in, victim_addr_in, fill_addr_in, block_data_in,
      output mem_ready_in, mem_rvalid_in, mem_rdata_in,
      input  block_data_out, replace_ack_out, busy_out,
      input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out
   );
endinterface

// File: rtl/cache_line_transfer_ctrl.sv
// Evicts a dirty victim line and refills a missed line, one memory beat at a time.
// All outputs are registered from the next-state decode so they align with the state.
module cache_line_transfer_ctrl
   import cache_line_transfer_ctrl_pkg::*;
#(
   parameter int unsigned CACHE_BLOCK   = 512,
   parameter int unsigned MEM_BUS_WIDTH = 64,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned OFFSET_WIDTH  = 6
) (
   input  logic clk_in,
   input  logic rst_n_in,
   cache_line_transfer_ctrl_if.master bus
);

   localparam int unsigned L_BEATS = CACHE_BLOCK / MEM_BUS_WIDTH;
   localparam int unsigned CNT_W   = log(L_BEATS);
   localparam int unsigned IDX_W   = log(CACHE_BLOCK);
   localparam int unsigned BYTES   = MEM_BUS_WIDTH / 8;
   localparam logic [CNT_W-1:0]         LAST     = CNT_W'(L_BEATS - 1);
   localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'((64'd1 << OFFSET_WIDTH) - 64'd1);

   state_t                   r_state, w_state_nxt;
   logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
   logic                     w_latch, w_store;
   logic [ADDRESS_WIDTH-1:0] r_vic_base, r_fill_base, w_vic_base_nxt, w_fill_base_nxt;
   logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nxt, w_off;
   logic [CACHE_BLOCK-1:0]   r_vic_line, w_vic_line_nxt, r_fill_line;
   logic [MEM_BUS_WIDTH-1:0] r_wdata, w_wdata_nxt;
   logic [IDX_W-1:0]         w_wr_lsb, w_st_lsb;
   logic                     r_req, r_we, r_ack, r_busy;
   logic                     w_req_nxt, w_we_nxt, w_ack_nxt, w_busy_nxt;

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state, beat counter and registered-output decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_store     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.replace_req_in) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = bus.dirty_bit_in ? ST_WB_REQ : ST_FILL_REQ;
            end
         end
         ST_WB_REQ: begin
            if (bus.mem_ready_in) begin
               if (r_cnt == LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_FILL_REQ;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_FILL_REQ: begin
            if (bus.mem_ready_in) w_state_nxt = ST_FILL_WAIT;
         end
         ST_FILL_WAIT: begin
            if (bus.mem_rvalid_in) begin
               w_store = 1'b1;
               if (r_cnt == LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
                  w_state_nxt = ST_FILL_REQ;
               end
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase

      // Latched values are bypassed on the capture edge so beat 0 is ready immediately
      w_vic_base_nxt  = w_latch ? (bus.victim_addr_in & ~OFF_MASK) : r_vic_base;
      w_fill_base_nxt = w_latch ? (bus.fill_addr_in & ~OFF_MASK) : r_fill_base;
      w_vic_line_nxt  = w_latch ? bus.block_data_in : r_vic_line;

      w_off      = ADDRESS_WIDTH'(w_cnt_nxt) * ADDRESS_WIDTH'(BYTES);
      w_wr_lsb   = IDX_W'(w_cnt_nxt) * IDX_W'(MEM_BUS_WIDTH);
      w_st_lsb   = IDX_W'(r_cnt) * IDX_W'(MEM_BUS_WIDTH);
      w_req_nxt  = (w_state_nxt == ST_WB_REQ) || (w_state_nxt == ST_FILL_REQ);
      w_we_nxt   = (w_state_nxt == ST_WB_REQ);
      w_ack_nxt  = (w_state_nxt == ST_DONE);
      w_busy_nxt = (w_state_nxt != ST_IDLE);

      w_addr_nxt  = '0;
      w_wdata_nxt = '0;
      if (w_state_nxt == ST_WB_REQ) begin
         w_addr_nxt  = w_vic_base_nxt + w_off;
         w_wdata_nxt = w_vic_line_nxt[w_wr_lsb +: MEM_BUS_WIDTH];
      end else if (w_state_nxt == ST_FILL_REQ) begin
         w_addr_nxt  = w_fill_base_nxt + w_off;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_cnt       <= '0;
         r_vic_base  <= '0;
         r_fill_base <= '0;
         r_vic_line  <= '0;
         r_fill_line <= '0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_ack       <= 1'b0;
         r_busy      <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_vic_base  <= w_vic_base_nxt;
         r_fill_base <= w_fill_base_nxt;
         r_vic_line  <= w_vic_line_nxt;
         if (w_store) r_fill_line[w_st_lsb +: MEM_BUS_WIDTH] <= bus.mem_rdata_in;
         r_req       <= w_req_nxt;
         r_we        <= w_we_nxt;
         r_ack       <= w_ack_nxt;
         r_busy      <= w_busy_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
      end
   end

   assign bus.mem_req_out     = r_req;
   assign bus.mem_we_out      = r_we;
   assign bus.mem_addr_out    = r_addr;
   assign bus.mem_wdata_out   = r_wdata;
   assign bus.replace_ack_out = r_ack;
   assign bus.busy_out        = r_busy;
   assign bus.block_data_out  = r_fill_line;

endmodule
